// File: rtl/qmem_pkg.sv
// Shared qmem definitions: default bus widths, arbiter state encoding and master-index width helper.
package qmem_pkg;

  localparam int QMEM_QAW = 32;
  localparam int QMEM_QDW = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GNT  = 1'b1
  } arb_state_t;

  // A single master still needs a 1-bit index so ports never collapse to zero width.
  function automatic int qmem_miw(input int mn);
    return (mn > 1) ? $clog2(mn) : 1;
  endfunction

endpackage

// File: rtl/qmem_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last_idx+1 with wrap.
// Rotates the request vector to start after last_idx, priority-encodes it, then rotates the index back.
module qmem_rr_pick
  import qmem_pkg::*;
#(
  parameter  int MN  = 2,
  localparam int MIW = qmem_miw(MN)
) (
  input  logic [MN-1:0]  req,
  input  logic [MIW-1:0] last_idx,
  output logic           any,
  output logic [MIW-1:0] idx
);

  logic [MN-1:0] w_rot;
  int            w_base;
  int            w_off;

  always_comb begin
    w_base = (int'(last_idx) + 1) % MN;
    w_rot  = '0;
    for (int k = 0; k < MN; k++) begin
      w_rot[MIW'(k)] = req[MIW'((w_base + k) % MN)];
    end
    w_off = 0;
    for (int k = MN - 1; k >= 0; k--) begin
      if (w_rot[MIW'(k)]) w_off = k;
    end
    any = |req;
    idx = MIW'((w_base + w_off) % MN);
  end

endmodule

// File: rtl/qmem_arbiter.sv
// Round-robin arbiter sharing one qmem slave bus among MN masters; grant registered (cs->qs_cs 1 cycle).
// Forwarded fields follow the winner combinationally, so the winner or slave may stall indefinitely.
module qmem_arbiter
  import qmem_pkg::*;
#(
  parameter  int QAW = QMEM_QAW,
  parameter  int QDW = QMEM_QDW,
  parameter  int QSW = QDW / 8,
  parameter  int MN  = 2,
  localparam int MIW = qmem_miw(MN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MN-1:0]     qm_cs,
  input  logic [MN-1:0]     qm_we,
  input  logic [MN*QAW-1:0] qm_adr,
  input  logic [MN*QSW-1:0] qm_sel,
  input  logic [MN*QDW-1:0] qm_dat_w,
  output logic [MN*QDW-1:0] qm_dat_r,
  output logic [MN-1:0]     qm_ack,
  output logic [MN-1:0]     qm_err,
  output logic              qs_cs,
  output logic              qs_we,
  output logic [QAW-1:0]    qs_adr,
  output logic [QSW-1:0]    qs_sel,
  output logic [QDW-1:0]    qs_dat_w,
  input  logic [QDW-1:0]    qs_dat_r,
  input  logic              qs_ack,
  input  logic              qs_err,
  output logic [MN-1:0]     gnt,
  output logic              busy,
  output logic [MIW-1:0]    rd_idx
);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [MIW-1:0] r_gnt_idx;
  logic [MIW-1:0] r_last_idx;
  logic [MIW-1:0] r_rd_idx;
  logic           w_pick_any;
  logic [MIW-1:0] w_pick_idx;
  logic           w_done;

  qmem_rr_pick #(.MN(MN)) u_pick (
    .req      (qm_cs),
    .last_idx (r_last_idx),
    .any      (w_pick_any),
    .idx      (w_pick_idx)
  );

  always_comb begin
    qs_adr   = '0;
    qs_sel   = '0;
    qs_dat_w = '0;
    for (int i = 0; i < MN; i++) begin
      if (r_gnt_idx == MIW'(i)) begin
        qs_adr   = qm_adr[QAW*i +: QAW];
        qs_sel   = qm_sel[QSW*i +: QSW];
        qs_dat_w = qm_dat_w[QDW*i +: QDW];
      end
    end
  end

  // Outputs are masked while rst is high so an ack arriving in the reset cycle never leaks out.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    qs_cs       = 1'b0;
    qs_we       = 1'b0;
    qm_ack      = '0;
    qm_err      = '0;
    gnt         = '0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) w_state_nxt = ST_GNT;
      end
      ST_GNT: begin
        if (!rst) begin
          busy              = 1'b1;
          gnt[r_gnt_idx]    = 1'b1;
          qs_cs             = qm_cs[r_gnt_idx];
          qs_we             = qm_we[r_gnt_idx];
          qm_ack[r_gnt_idx] = qs_ack;
          qm_err[r_gnt_idx] = qs_err;
        end
        if (!qm_cs[r_gnt_idx]) begin
          w_state_nxt = ST_IDLE;
        end else if (qs_ack || qs_err) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_idx  <= '0;
      r_last_idx <= MIW'(MN - 1);
      r_rd_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_pick_any) r_gnt_idx <= w_pick_idx;
      if (w_done) begin
        r_last_idx <= r_gnt_idx;
        if (!qm_we[r_gnt_idx]) r_rd_idx <= r_gnt_idx;
      end
    end
  end

  assign qm_dat_r = {MN{qs_dat_r}};
  assign rd_idx   = r_rd_idx;

endmodule

// File: tb/tb_qmem_arbiter.sv
// Bench for qmem_arbiter (MN=4): directed scenarios plus random masters/slave vs. a round-robin reference.
module tb_qmem_arbiter;

  localparam int MN  = 4;
  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int MIW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [MN-1:0]     qm_cs, qm_we, qm_ack, qm_err, gnt;
  logic [MN*QAW-1:0] qm_adr;
  logic [MN*QSW-1:0] qm_sel;
  logic [MN*QDW-1:0] qm_dat_w, qm_dat_r;
  logic              qs_cs, qs_we, qs_ack, qs_err, busy;
  logic [QAW-1:0]    qs_adr;
  logic [QSW-1:0]    qs_sel;
  logic [QDW-1:0]    qs_dat_w, qs_dat_r;
  logic [MIW-1:0]    rd_idx;

  always #5 clk = ~clk;

  qmem_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN)) dut (
    .clk(clk), .rst(rst),
    .qm_cs(qm_cs), .qm_we(qm_we), .qm_adr(qm_adr), .qm_sel(qm_sel),
    .qm_dat_w(qm_dat_w), .qm_dat_r(qm_dat_r), .qm_ack(qm_ack), .qm_err(qm_err),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_adr(qs_adr), .qs_sel(qs_sel),
    .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
    .gnt(gnt), .busy(busy), .rd_idx(rd_idx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Master intent, slave behaviour and the reference arbiter view.
  logic [MN-1:0]  req_on, req_we;
  logic [QAW-1:0] req_adr [MN];
  logic [QSW-1:0] req_sel [MN];
  logic [QDW-1:0] req_dat [MN];
  bit  rst_nxt, rand_en, hold_en, force_ack, dat_force;
  logic [QDW-1:0] dat_val;
  int  fix_wait, fix_err;
  bit  m_busy;
  int  m_gnt, m_last, m_rd;
  int  s_wait;
  bit  s_err;
  bit  rd_chk;
  int  rd_who;
  int  cyc;
  logic [MN-1:0]     obs_ack, obs_err, obs_gnt;
  logic              obs_cs, obs_busy;
  logic [MN*QDW-1:0] obs_dat_r;
  logic [MIW-1:0]    obs_rd;

  function automatic int rr_next(input int last, input logic [MN-1:0] cs);
    for (int k = 1; k <= MN; k++) begin
      if (cs[(last + k) % MN]) return (last + k) % MN;
    end
    return -1;
  endfunction

  function automatic int oh2idx(input logic [MN-1:0] v);
    for (int i = 0; i < MN; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic new_req(input int i, input bit we);
    req_on[i]  = 1'b1;
    req_we[i]  = we;
    req_adr[i] = $urandom;
    req_sel[i] = QSW'($urandom);
    req_dat[i] = $urandom;
  endtask

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_last = MN - 1; m_rd = 0; rd_chk = 0; s_wait = 0; s_err = 0;
  endtask

  task automatic run_cycle();
    bit             exp_busy;
    logic [MN-1:0]  oh;
    int             w;
    @(posedge clk);
    #1;
    if (rand_en) begin
      for (int i = 0; i < MN; i++) begin
        if (m_busy && i == m_gnt && req_on[i] && $urandom_range(0, 15) == 0) req_on[i] = 1'b0;
        else if (!req_on[i] && $urandom_range(0, 2) == 0) new_req(i, 1'($urandom));
      end
    end
    if (hold_en) begin
      for (int i = 0; i < MN; i++) if (!req_on[i]) new_req(i, 1'($urandom));
    end
    rst = rst_nxt;
    for (int i = 0; i < MN; i++) begin
      qm_cs[i]               = req_on[i];
      qm_we[i]               = req_we[i];
      qm_adr[QAW*i +: QAW]   = req_adr[i];
      qm_sel[QSW*i +: QSW]   = req_sel[i];
      qm_dat_w[QDW*i +: QDW] = req_dat[i];
    end
    qs_dat_r = dat_force ? dat_val : QDW'($urandom);
    qs_ack = 1'b0;
    qs_err = 1'b0;
    #1;
    if (force_ack) qs_ack = 1'b1;
    else if (qs_cs && !rst) begin
      if (s_wait == 0) begin
        if (s_err) qs_err = 1'b1;
        else       qs_ack = 1'b1;
      end else s_wait--;
    end
    #1;
    exp_busy = m_busy && !rst;
    oh = '0;
    if (exp_busy) oh[m_gnt] = 1'b1;
    chk("busy", busy, exp_busy);
    chk("gnt", gnt, oh);
    chk("qs_cs", qs_cs, exp_busy && req_on[m_gnt]);
    if (exp_busy)
      chk("qs_fields", {qs_we, qs_adr, qs_sel, qs_dat_w},
          {req_we[m_gnt], req_adr[m_gnt], req_sel[m_gnt], req_dat[m_gnt]});
    chk("ack", qm_ack, qs_ack ? oh : '0);
    chk("err", qm_err, qs_err ? oh : '0);
    chk("dat_r", qm_dat_r, {MN{qs_dat_r}});
    chk("rd_idx", rd_idx, 128'(m_rd));
    if (rd_chk) chk("rd_dat", qm_dat_r[QDW*rd_who +: QDW], qs_dat_r);
    rd_chk = 0;
    obs_ack = qm_ack; obs_err = qm_err; obs_gnt = gnt; obs_cs = qs_cs;
    obs_busy = busy; obs_dat_r = qm_dat_r; obs_rd = rd_idx;
    if (rst) model_reset();
    else if (m_busy) begin
      if (!req_on[m_gnt]) m_busy = 0;
      else if (qs_ack || qs_err) begin
        m_last = m_gnt;
        if (!req_we[m_gnt]) begin
          m_rd = m_gnt; rd_chk = 1; rd_who = m_gnt;
        end
        req_on[m_gnt] = 1'b0;
        m_busy = 0;
      end
    end else begin
      w = rr_next(m_last, req_on);
      if (w >= 0) begin
        m_busy = 1;
        m_gnt  = w;
        s_wait = (fix_wait >= 0) ? fix_wait : $urandom_range(0, 3);
        s_err  = (fix_err >= 0) ? (fix_err != 0) : ($urandom_range(0, 5) == 0);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_nxt = 1; req_on = '0;
    run_cycle();
    rst_nxt = 0;
  endtask

  int ng, last_cyc, idx;
  bit prev_busy;

  initial begin
    rst = 1'b1; rst_nxt = 1; rand_en = 0; hold_en = 0; force_ack = 0; dat_force = 0;
    dat_val = '0; fix_wait = 0; fix_err = 0; cyc = 0;
    req_on = '0; req_we = '0;
    for (int i = 0; i < MN; i++) begin
      req_adr[i] = '0; req_sel[i] = '0; req_dat[i] = '0;
    end
    qm_cs = '0; qm_we = '0; qm_adr = '0; qm_sel = '0; qm_dat_w = '0;
    qs_dat_r = '0; qs_ack = 0; qs_err = 0;
    model_reset();

    // Master 1 requests at cycle 2 against a zero-wait slave.
    run_cycle(); run_cycle();
    rst_nxt = 0;
    new_req(1, 1'b1);
    run_cycle();
    chk("rst_busy", obs_busy, 0);
    chk("rst_gnt", obs_gnt, 0);
    chk("rst_cs", obs_cs, 0);
    run_cycle();
    chk("s1_cs", obs_cs, 1);
    chk("s1_ack", obs_ack, 4'b0010);
    run_cycle();
    chk("s1_busy", obs_busy, 0);

    // Read by master 2; data arrives the cycle after ack.
    new_req(2, 1'b0);
    run_cycle(); run_cycle();
    dat_force = 1; dat_val = 32'hDEADBEEF;
    run_cycle();
    chk("rd2_dat", obs_dat_r[QDW*2 +: QDW], 32'hDEADBEEF);
    chk("rd2_idx", obs_rd, 2);
    dat_force = 0;

    // Error on master 0 is terminal; pending master 1 wins next.
    do_reset();
    new_req(0, 1'b1); new_req(1, 1'b1);
    fix_err = 1;
    run_cycle(); run_cycle();
    chk("err0", obs_err, 4'b0001);
    chk("err0_ack", obs_ack, 4'b0000);
    fix_err = 0;
    run_cycle(); run_cycle();
    chk("err_next", obs_gnt, 4'b0010);
    repeat (3) run_cycle();

    // Granted master withdraws while the slave waits; pointer must not move.
    do_reset();
    new_req(0, 1'b1);
    fix_wait = 3;
    run_cycle(); run_cycle();
    req_on[0] = 1'b0;
    run_cycle();
    chk("wd_cs", obs_cs, 0);
    chk("wd_ack", obs_ack, 4'b0000);
    fix_wait = 0;
    new_req(0, 1'b1); new_req(1, 1'b1);
    run_cycle(); run_cycle();
    chk("wd_regrant", obs_gnt, 4'b0001);
    repeat (4) run_cycle();

    // Reset in the middle of a 5-wait-state transaction with an ack in the reset cycle.
    do_reset();
    new_req(3, 1'b1);
    fix_wait = 5;
    run_cycle(); run_cycle(); run_cycle();
    rst_nxt = 1; force_ack = 1;
    run_cycle();
    chk("rm_ack_in_rst", obs_ack, 4'b0000);
    rst_nxt = 0; force_ack = 0; req_on[3] = 1'b0;
    run_cycle();
    chk("rm_cs", obs_cs, 0);
    chk("rm_gnt", obs_gnt, 0);
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      chk("rm_noack", obs_ack, 4'b0000);
    end

    // All masters hold cs: grant order 0,1,2,3,0 two cycles apart.
    do_reset();
    fix_wait = 0; fix_err = 0; hold_en = 1;
    ng = 0; prev_busy = 0; last_cyc = 0;
    for (int c = 0; c < 12; c++) begin
      run_cycle();
      if (obs_busy && !prev_busy) begin
        idx = oh2idx(obs_gnt);
        if (ng < 5) begin
          chk("rr_order", 128'(idx), 128'(ng % MN));
          if (ng > 0) chk("rr_gap", 128'(cyc - last_cyc), 2);
        end
        ng++;
        last_cyc = cyc;
      end
      prev_busy = obs_busy;
    end
    chk("rr_count", 128'(ng >= 5), 1);
    hold_en = 0;
    repeat (12) run_cycle();

    // Random masters, wait states, errors and withdrawals.
    do_reset();
    fix_wait = -1; fix_err = -1; rand_en = 1;
    repeat (3000) run_cycle();
    rand_en = 0;
    repeat (20) run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
